mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mycpu_pkg.sv | 35 +++
 rtl/mem_stage_load_align.sv | 38 +++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared stage-bus widths, field offsets and load-type encodings
package mycpu_pkg;

  localparam int ES2MS_BUS_WD = 163;
  localparam int MS2WS_BUS_WD = 158;
  localparam int MS2DS_FWD_WD = 39;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } ld_type_e;

  // es_to_ms bus: {ld_type, res_from_mem, req_issued, ms_to_ws fields}
  localparam int ES_LD_TYPE_LSB      = 160;
  localparam int ES_RES_FROM_MEM_BIT = 159;
  localparam int ES_REQ_ISSUED_BIT   = 158;

  // ms_to_ws bus field offsets
  localparam int MS_EX_BIT          = 157;
  localparam int MS_ERTN_BIT        = 156;
  localparam int MS_CSR_WVALUE_LSB  = 124;
  localparam int MS_ECODE_LSB       = 118;
  localparam int MS_CSR_RE_BIT      = 117;
  localparam int MS_CSR_WE_BIT      = 116;
  localparam int MS_CSR_NUM_LSB     = 102;
  localparam int MS_CSR_WMASK_LSB   = 70;
  localparam int MS_GR_WE_BIT       = 69;
  localparam int MS_DEST_LSB        = 64;
  localparam int MS_RESULT_LSB      = 32;
  localparam int MS_PC_LSB          = 0;

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - combinational load data extraction (byte/half select, sign/zero extend)
module load_align
  import mycpu_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Encodings 101-111 fall into the default word load.
  always_comb begin
    value = rdata;
    case (ld_type_e'(ld_type))
      LD_B:    value = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    value = {{16{half_sel[15]}}, half_sel};
      LD_BU:   value = {24'd0, byte_sel};
      LD_HU:   value = {16'd0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage; MS_LOAD_FWD_EN enables forwarding of load data once it arrives
module mem_stage
  import mycpu_pkg::*;
#(
  parameter int ES_TO_MS_BUS_WD = ES2MS_BUS_WD,
  parameter int MS_TO_WS_BUS_WD = MS2WS_BUS_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_flush_pipe,
  output logic [MS2DS_FWD_WD-1:0]    ms_to_ds_fwd,
  output logic                       ms_ex
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic                       resp_got;
  logic [31:0]                resp_buf;
  logic [1:0]                 cancel_cnt;

  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        req_issued;
  logic        ex;
  logic        ertn;
  logic        csr_re;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] ms_result;

  assign ld_type      = es_bus_r[ES_LD_TYPE_LSB +: 3];
  assign res_from_mem = es_bus_r[ES_RES_FROM_MEM_BIT];
  assign req_issued   = es_bus_r[ES_REQ_ISSUED_BIT];
  assign ex           = es_bus_r[MS_EX_BIT];
  assign ertn         = es_bus_r[MS_ERTN_BIT];
  assign csr_re       = es_bus_r[MS_CSR_RE_BIT];
  assign gr_we        = es_bus_r[MS_GR_WE_BIT];
  assign dest         = es_bus_r[MS_DEST_LSB +: 5];
  assign ms_result    = es_bus_r[MS_RESULT_LSB +: 32];

  // Responses that belong to flushed requests are swallowed while cancel_cnt is nonzero.
  logic accepted_data_ok;
  logic data_available;
  logic ms_ready_go;
  logic ms_leave;
  logic cancel_inc;

  assign accepted_data_ok = data_sram_data_ok && (cancel_cnt == 2'd0);
  assign data_available   = resp_got || accepted_data_ok;
  assign ms_ready_go      = !(req_issued && !ex && !resp_got && !accepted_data_ok);
  assign ms_allowin       = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_leave         = ms_valid && ms_ready_go && ws_allowin;
  assign ms_to_ws_valid   = ms_valid && ms_ready_go && !ws_flush_pipe;
  assign ms_ex            = ms_valid && (ex || ertn);
  assign cancel_inc       = ws_flush_pipe && ms_valid && req_issued && !resp_got
                            && !data_sram_data_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ws_flush_pipe) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_bus_r <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      es_bus_r <= es_to_ms_bus;
    end
  end

  // Hold a response that arrives while write-back is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_got <= 1'b0;
      resp_buf <= 32'd0;
    end else if (ws_flush_pipe || ms_leave) begin
      resp_got <= 1'b0;
    end else if (ms_valid && accepted_data_ok && req_issued && !ex && !resp_got) begin
      resp_got <= 1'b1;
      resp_buf <= data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cancel_cnt <= 2'd0;
    end else if (cancel_inc) begin
      if (cancel_cnt != 2'd3) begin
        cancel_cnt <= cancel_cnt + 2'd1;
      end
    end else if (data_sram_data_ok && cancel_cnt != 2'd0) begin
      cancel_cnt <= cancel_cnt - 2'd1;
    end
  end

  logic [31:0] load_src;
  logic [31:0] load_value;
  logic [31:0] final_result;

  assign load_src = resp_got ? resp_buf : data_sram_rdata;

  load_align u_load_align (
    .ld_type (ld_type),
    .addr_lo (ms_result[1:0]),
    .rdata   (load_src),
    .value   (load_value)
  );

  assign final_result = (res_from_mem && !ex) ? load_value : ms_result;

  always_comb begin
    ms_to_ws_bus = es_bus_r[MS_TO_WS_BUS_WD-1:0];
    ms_to_ws_bus[MS_RESULT_LSB +: 32] = final_result;
  end

  logic        fwd_valid;
  logic        fwd_blocked;
  logic [31:0] fwd_data;

  assign fwd_valid = ms_valid && gr_we;

`ifdef MS_LOAD_FWD_EN
  assign fwd_blocked = (fwd_valid && res_from_mem && !data_available) || (ms_valid && csr_re);
  assign fwd_data    = final_result;
`else
  // Load data is never forwarded from here, so any load holds the consumer.
  assign fwd_blocked = (fwd_valid && res_from_mem) || (ms_valid && csr_re);
  assign fwd_data    = ms_result;
  logic unused_data_available;
  assign unused_data_available = data_available;
`endif

  assign ms_to_ds_fwd = {fwd_valid, fwd_blocked, dest, fwd_data};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         es_to_ms_valid;
  logic [162:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [157:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_flush_pipe;
  logic [38:0]  ms_to_ds_fwd;
  logic         ms_ex;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_flush_pipe     (ws_flush_pipe),
    .ms_to_ds_fwd      (ms_to_ds_fwd),
    .ms_ex             (ms_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish within time budget");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [162:0] mk(input logic [2:0] ldt, input logic rfm, input logic req,
                                      input logic ex, input logic csr_re, input logic gr_we,
                                      input logic [4:0] dest, input logic [31:0] res,
                                      input logic [31:0] pc);
    logic [162:0] b;
    b = '0;
    b[162:160] = ldt;
    b[159] = rfm;
    b[158] = req;
    b[157] = ex;
    b[117] = csr_re;
    b[69] = gr_we;
    b[68:64] = dest;
    b[63:32] = res;
    b[31:0] = pc;
    return b;
  endfunction

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_transfer: got pc 0x%08h expected no transfer", ms_to_ws_bus[31:0]);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("xfer_result", ms_to_ws_bus[63:32], e[63:32]);
        chk("xfer_pc", ms_to_ws_bus[31:0], e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [162:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    step();
    es_to_ms_valid = 1'b0;
  endtask

  logic exp_blk_on_data;

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'd0;
    ws_flush_pipe = 1'b0;
`ifdef MS_LOAD_FWD_EN
    exp_blk_on_data = 1'b0;
`else
    exp_blk_on_data = 1'b1;
`endif
    #2;
    chk("rst_to_ws_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("rst_allowin", {31'd0, ms_allowin}, 32'd1);
    chk("rst_ms_ex", {31'd0, ms_ex}, 32'd0);
    chk("rst_fwd_valid", {31'd0, ms_to_ds_fwd[38]}, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // ld.b at addr 3: one stall cycle then 0xFFFFFF80
    sb.push_back({32'hFFFF_FF80, 32'h0000_0100});
    issue(mk(3'b001, 1, 1, 0, 0, 1, 5'd5, 32'h0000_1003, 32'h0000_0100));
    #2;
    chk("ldb_stall_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("ldb_stall_allowin", {31'd0, ms_allowin}, 32'd0);
    chk("ldb_stall_fwd_blk", {31'd0, ms_to_ds_fwd[37]}, 32'd1);
    chk("ldb_fwd_dest", {27'd0, ms_to_ds_fwd[36:32]}, 32'd5);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF_FF12;
    #2;
    chk("ldb_data_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("ldb_data_fwd_blk", {31'd0, ms_to_ds_fwd[37]}, {31'd0, exp_blk_on_data});
    step();
    data_sram_data_ok = 1'b0;
    #2;
    chk("ldb_left", {31'd0, ms_to_ws_valid}, 32'd0);

    // ld.hu at addr 2 with write-back stalled for 3 cycles
    ws_allowin = 1'b0;
    sb.push_back({32'h0000_BEEF, 32'h0000_0200});
    issue(mk(3'b100, 1, 1, 0, 0, 1, 5'd6, 32'h0000_2002, 32'h0000_0200));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hBEEF_0000;
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'hDEAD_DEAD;
    #2;
    chk("ldhu_buf_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("ldhu_buf_result", ms_to_ws_bus[63:32], 32'h0000_BEEF);
    step();
    ws_allowin = 1'b1;
    step();
    #2;
    chk("ldhu_once", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("ldhu_allowin", {31'd0, ms_allowin}, 32'd1);

    // Flush during wait: stale response discarded, next load gets its own data
    issue(mk(3'b000, 1, 1, 0, 0, 1, 5'd7, 32'h0000_3000, 32'h0000_0300));
    ws_flush_pipe = 1'b1;
    #2;
    chk("flush_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    step();
    ws_flush_pipe = 1'b0;
    #2;
    chk("flush_allowin", {31'd0, ms_allowin}, 32'd1);
    chk("flush_cancel_cnt", {30'd0, dut.cancel_cnt}, 32'd1);
    sb.push_back({32'h1234_5678, 32'h0000_0310});
    issue(mk(3'b000, 1, 1, 0, 0, 1, 5'd8, 32'h0000_3100, 32'h0000_0310));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hAAAA_AAAA;
    #2;
    chk("stale_discard", {31'd0, ms_to_ws_valid}, 32'd0);
    step();
    data_sram_rdata = 32'h1234_5678;
    #2;
    chk("own_data_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    step();
    data_sram_data_ok = 1'b0;

    // Flush and data_ok together: nothing left to cancel
    issue(mk(3'b000, 1, 1, 0, 0, 1, 5'd9, 32'h0000_4000, 32'h0000_0400));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    ws_flush_pipe = 1'b1;
    #2;
    chk("flush_ok_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    step();
    data_sram_data_ok = 1'b0;
    ws_flush_pipe = 1'b0;
    #2;
    chk("flush_ok_cancel_cnt", {30'd0, dut.cancel_cnt}, 32'd0);
    sb.push_back({32'h0000_009A, 32'h0000_0500});
    issue(mk(3'b011, 1, 1, 0, 0, 1, 5'd10, 32'h0000_5001, 32'h0000_0500));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_9A00;
    #2;
    chk("ldbu_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    step();
    data_sram_data_ok = 1'b0;

    // Excepting load: no wait, latched result
    sb.push_back({32'h0000_6003, 32'h0000_0600});
    issue(mk(3'b001, 1, 1, 1, 0, 1, 5'd11, 32'h0000_6003, 32'h0000_0600));
    #2;
    chk("ex_ms_ex", {31'd0, ms_ex}, 32'd1);
    chk("ex_no_stall", {31'd0, ms_to_ws_valid}, 32'd1);
    step();

    // CSR read blocks forwarding; plain ALU result forwards
    ws_allowin = 1'b0;
    sb.push_back({32'h0000_7777, 32'h0000_0700});
    issue(mk(3'b000, 0, 0, 0, 1, 1, 5'd7, 32'h0000_7777, 32'h0000_0700));
    #2;
    chk("csr_fwd_valid", {31'd0, ms_to_ds_fwd[38]}, 32'd1);
    chk("csr_fwd_blk", {31'd0, ms_to_ds_fwd[37]}, 32'd1);
    ws_allowin = 1'b1;
    step();
    sb.push_back({32'h0000_CAFE, 32'h0000_0710});
    issue(mk(3'b000, 0, 0, 0, 0, 1, 5'd9, 32'h0000_CAFE, 32'h0000_0710));
    #2;
    chk("alu_fwd_blk", {31'd0, ms_to_ds_fwd[37]}, 32'd0);
    chk("alu_fwd_data", ms_to_ds_fwd[31:0], 32'h0000_CAFE);
    step();

    // Reset mid-wait with one cancel outstanding
    issue(mk(3'b000, 1, 1, 0, 0, 1, 5'd12, 32'h0000_8000, 32'h0000_0800));
    ws_flush_pipe = 1'b1;
    step();
    ws_flush_pipe = 1'b0;
    issue(mk(3'b000, 1, 1, 0, 0, 1, 5'd13, 32'h0000_8100, 32'h0000_0810));
    #1;
    reset = 1'b1;
    #1;
    chk("arst_to_ws_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("arst_ms_ex", {31'd0, ms_ex}, 32'd0);
    chk("arst_fwd_valid", {31'd0, ms_to_ds_fwd[38]}, 32'd0);
    chk("arst_cancel_cnt", {30'd0, dut.cancel_cnt}, 32'd0);
    step();
    reset = 1'b0;
    #2;
    chk("arst_allowin", {31'd0, ms_allowin}, 32'd1);
    step();
    sb.push_back({32'hFFFF_8001, 32'h0000_0900});
    issue(mk(3'b010, 1, 1, 0, 0, 1, 5'd14, 32'h0000_9000, 32'h0000_0900));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_8001;
    #2;
    chk("post_rst_ldh_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    step();
    data_sram_data_ok = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
